instr_fetch_buffer: RTL and testbench

- Fetch stage directly downstream of program_cntr.
- Takes the word-index address and read_valid from the PC and issues reads to a synchronous instruction memory with fixed 1-cycle read latency.
- Queues the returned {address, instruction} pairs in a small FIFO and presents them to the SIMD decoder over a valid/ready handshake.
- Drives the PC's enable input as back-pressure, so the PC never advances past an address the buffer cannot hold.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/instr_fetch_buffer_if.sv | 33 +++
 rtl/fetch_fifo.sv | 52 +++++
 rtl/instr_fetch_buffer.sv | 79 +++++++
 tb/tb_instr_fetch_buffer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 32;
    localparam int IMEM_LATENCY = 1;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// PC, instruction-memory and decoder-side signals of the fetch buffer.
interface instr_fetch_buffer_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int IMEM_AW = 8,
    parameter int DEPTH   = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]  pc_addr;
    logic               pc_valid;
    logic               pc_enable;
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [DATA_W-1:0]  imem_rdata;
    logic               flush;
    logic               instr_valid;
    logic [DATA_W-1:0]  instr_data;
    logic [ADDR_W-1:0]  instr_addr;
    logic               instr_ready;
    logic [CW-1:0]      occupancy;

    modport slave (
        input  pc_addr, pc_valid, imem_rdata, flush, instr_ready,
        output pc_enable, imem_en, imem_addr, instr_valid, instr_data, instr_addr, occupancy
    );

    modport master (
        output pc_addr, pc_valid, imem_rdata, flush, instr_ready,
        input  pc_enable, imem_en, imem_addr, instr_valid, instr_data, instr_addr, occupancy
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through FIFO of fetch entries; clear drops all contents.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  entry_t        wdata,
    output logic [CW-1:0] count,
    output entry_t        head
);
    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;

    assign do_pop = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !clear) mem[wr_ptr] <= wdata;
    end

    // Empty presents zeros so nothing stale leaks out after reset or flush.
    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: issues PC reads to a 1-cycle imem, buffers {addr, instr} for the decoder.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int IMEM_AW = 8,
    parameter int DEPTH   = 4
) (
    input logic                 clk,
    input logic                 rst,
    instr_fetch_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = DEPTH[CW:0];

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    generate
        if (IMEM_LATENCY != 1) begin : g_lat_chk
            $error("instr_fetch_buffer requires a 1-cycle instruction memory");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
            $error("instr_fetch_buffer DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic              inflight;
    logic [ADDR_W-1:0] resp_addr;
    logic [CW-1:0]     count;
    logic              req;
    logic              push;
    entry_t            wr_entry;
    entry_t            head;

    // The outstanding read is budgeted, so its returning word always has a slot.
    assign bus.pc_enable = !rst && !bus.flush &&
                           (({1'b0, count} + {{CW{1'b0}}, inflight}) < DEPTH_LIM);

    assign req           = bus.pc_enable && bus.pc_valid;
    assign bus.imem_en   = req;
    assign bus.imem_addr = bus.pc_addr[IMEM_AW-1:0];

    assign push     = inflight && !bus.flush && !rst;
    assign wr_entry = '{addr: resp_addr, data: bus.imem_rdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight  <= 1'b0;
            resp_addr <= '0;
        end else begin
            inflight <= req;
            if (req) resp_addr <= bus.pc_addr;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (bus.instr_ready),
        .clear (bus.flush),
        .wdata (wr_entry),
        .count (count),
        .head  (head)
    );

    assign bus.instr_valid = (count != '0);
    assign bus.instr_data  = head.data;
    assign bus.instr_addr  = head.addr;
    assign bus.occupancy   = count;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer with a queue scoreboard checked at every decoder pop.
module tb_instr_fetch_buffer;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_buffer_if #(.DEPTH(DEPTH)) bus ();

    instr_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_mon;
    int          n_pass  = 0;
    int          n_total = 0;
    int          n_req;
    logic [31:0] redirect = 32'h0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, want);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // PC and instruction memory models: word n holds 0x1000_0000 + n.
    always @(posedge clk) begin
        if (rst)                               bus.pc_addr <= 32'h0;
        else if (bus.flush)                    bus.pc_addr <= redirect;
        else if (bus.pc_enable && bus.pc_valid) bus.pc_addr <= bus.pc_addr + 32'd1;
        if (bus.imem_en) bus.imem_rdata <= 32'h1000_0000 + {24'h0, bus.imem_addr};
    end

    // Scoreboard: accepted requests enqueue, decoder handshakes dequeue and compare.
    always @(negedge clk) begin
        if (!rst && !bus.flush && bus.instr_valid && bus.instr_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL pop_unexpected: got addr %0h expected no entry", bus.instr_addr);
            end else begin
                e_mon = exp_q.pop_front();
                chk("pop_addr", 64'(bus.instr_addr), 64'(e_mon.addr));
                chk("pop_data", 64'(bus.instr_data), 64'(e_mon.data));
            end
        end
        chk("no_overflow", 64'(bus.occupancy <= 3'(DEPTH)), 64'd1);
        if (bus.occupancy == 3'(DEPTH)) chk("no_req_when_full", 64'(bus.imem_en), 64'd0);
        if (rst || bus.flush) exp_q.delete();
        else if (bus.imem_en)
            exp_q.push_back('{addr: bus.pc_addr,
                              data: 32'h1000_0000 + {24'h0, bus.pc_addr[7:0]}});
    end

    initial begin
        rst             = 1'b1;
        bus.pc_valid    = 1'b1;
        bus.instr_ready = 1'b1;
        bus.flush       = 1'b0;

        // Reset then free-run
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst_valid", 64'(bus.instr_valid), 64'd0);
        chk("rst_addr", 64'(bus.instr_addr), 64'd0);
        chk("rst_data", 64'(bus.instr_data), 64'd0);
        chk("pc_en_after_rst", 64'(bus.pc_enable), 64'd1);
        chk("first_req_addr", 64'(bus.imem_addr), 64'd0);
        cyc();
        @(negedge clk);
        chk("lat_t1_valid", 64'(bus.instr_valid), 64'd0);
        cyc();
        @(negedge clk);
        chk("lat_t2_valid", 64'(bus.instr_valid), 64'd1);
        chk("lat_t2_addr", 64'(bus.instr_addr), 64'd0);
        chk("lat_t2_data", 64'(bus.instr_data), 64'h1000_0000);
        repeat (6) cyc();

        // Back-pressure fill
        rst = 1'b1;
        bus.instr_ready = 1'b0;
        cyc();
        rst = 1'b0;
        n_req = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.imem_en) n_req++;
            cyc();
        end
        @(negedge clk);
        chk("fill_req_count", 64'(n_req), 64'd4);
        chk("fill_occupancy", 64'(bus.occupancy), 64'd4);
        chk("fill_pc_en", 64'(bus.pc_enable), 64'd0);
        chk("fill_head_addr", 64'(bus.instr_addr), 64'd0);

        // Full, one-cycle pop
        cyc();
        bus.instr_ready = 1'b1;
        cyc();
        bus.instr_ready = 1'b0;
        @(negedge clk);
        chk("fullpop_occupancy", 64'(bus.occupancy), 64'd3);
        chk("fullpop_pc_en", 64'(bus.pc_enable), 64'd1);
        chk("fullpop_req_addr", 64'(bus.imem_addr), 64'd4);
        cyc();
        @(negedge clk);
        chk("refill_pc_en", 64'(bus.pc_enable), 64'd0);
        chk("refill_occ_mid", 64'(bus.occupancy), 64'd3);
        cyc();
        @(negedge clk);
        chk("refill_occupancy", 64'(bus.occupancy), 64'd4);

        // Stall hold: ready 1,0,0,1
        cyc();
        bus.instr_ready = 1'b1;
        cyc();
        bus.instr_ready = 1'b0;
        @(negedge clk);
        chk("stall1_addr", 64'(bus.instr_addr), 64'd2);
        chk("stall1_data", 64'(bus.instr_data), 64'h1000_0002);
        cyc();
        @(negedge clk);
        chk("stall2_addr", 64'(bus.instr_addr), 64'd2);
        chk("stall2_data", 64'(bus.instr_data), 64'h1000_0002);
        chk("stall2_valid", 64'(bus.instr_valid), 64'd1);
        cyc();
        bus.instr_ready = 1'b1;
        repeat (8) cyc();

        // Flush with a response in flight
        rst = 1'b1;
        bus.instr_ready = 1'b0;
        redirect = 32'h40;
        cyc();
        rst = 1'b0;
        repeat (3) cyc();
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_pre_occupancy", 64'(bus.occupancy), 64'd2);
        chk("flush_pc_en", 64'(bus.pc_enable), 64'd0);
        cyc();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_occupancy", 64'(bus.occupancy), 64'd0);
        chk("flush_valid", 64'(bus.instr_valid), 64'd0);
        chk("flush_pc_en_after", 64'(bus.pc_enable), 64'd1);
        chk("flush_redirect_addr", 64'(bus.imem_addr), 64'h40);
        cyc();
        bus.instr_ready = 1'b1;
        repeat (6) cyc();

        // Reset mid-operation
        rst = 1'b1;
        bus.instr_ready = 1'b0;
        cyc();
        rst = 1'b0;
        repeat (4) cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_pre_occupancy", 64'(bus.occupancy), 64'd3);
        chk("midrst_no_req", 64'(bus.imem_en), 64'd0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("midrst_valid", 64'(bus.instr_valid), 64'd0);
        chk("midrst_addr", 64'(bus.instr_addr), 64'd0);
        chk("midrst_data", 64'(bus.instr_data), 64'd0);
        cyc();
        bus.instr_ready = 1'b1;
        repeat (8) cyc();

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
